// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing controller.
//   - FSM state encoding (IDLE / BUSY / RESP)
//   - Default requester count, beat width and adder latency
//   - clog2 helper used to size requester ids and the latency counter
package adder_share_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_ADD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a one-bit field always exists.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with lock support.
// Ports:
//   req      - request mask (one bit per requester)
//   ptr      - highest-priority requester when unlocked
//   lock     - when set only 'owner' may be granted
//   owner    - requester holding the lock
//   grant    - one-hot grant (all zero when nobody is eligible)
//   grant_id - encoded index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            lock,
    input  logic [ID_W-1:0] owner,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    // Candidate gi is the requester sitting gi places after the pointer.
    logic [ID_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = ID_W'((int'(ptr) + gi) % NREQ);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (lock) begin
            // A locked chain belongs to its owner even while its valid is low.
            if (req[owner]) begin
                grant_id     = owner;
                grant[owner] = 1'b1;
            end
        end else begin
            // Scan downwards so the candidate closest to the pointer wins.
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (cand_req[i]) begin
                    grant_id = cand_idx[i];
                end
            end
            if (|cand_req) begin
                grant[grant_id] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one external W-bit adder between NREQ
// requesters. Multi-beat operations chain the carry through the adder and
// hold a lock until the beat marked last.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   req_valid/last/cin [NREQ]       - per-requester beat handshake/control
//   req_a/req_b [NREQ*W]            - operands, requester i at [i*W +: W]
//   req_ready [NREQ]                - one-hot accept, combinational
//   rsp_valid/id/sum/cout/last      - one-cycle result pulse
//   add_a/add_b/add_cin             - to the shared adder
//   add_sum/add_cout                - from the shared adder (ADD_LAT cycles)
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int W       = DEF_W,
    parameter  int ADD_LAT = DEF_ADD_LAT,
    localparam int ID_W    = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout
);

    localparam int CNT_W = clog2(ADD_LAT + 1);

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [ID_W-1:0] ptr_reg, owner_reg, id_reg;
    logic            lock_reg, carry_reg, last_reg;
    logic [W-1:0]    add_a_reg, add_b_reg, sum_cap_reg;
    logic            add_cin_reg, cout_cap_reg;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*W +: W];
            assign b_arr[gi] = req_b[gi*W +: W];
        end
    endgenerate

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Arbitration view. In RESP the lock/pointer/carry updates being
    // committed this cycle are forwarded so a new beat can start immediately.
    logic            arb_en, arb_lock, carry_eff;
    logic [ID_W-1:0] arb_ptr, arb_owner;

    always_comb begin
        arb_en    = 1'b0;
        arb_lock  = lock_reg;
        arb_ptr   = ptr_reg;
        arb_owner = owner_reg;
        carry_eff = carry_reg;
        case (state_reg)
            ST_IDLE: arb_en = 1'b1;
            ST_RESP: begin
                arb_en    = 1'b1;
                carry_eff = cout_cap_reg;
                if (last_reg) begin
                    arb_lock = 1'b0;
                    arb_ptr  = next_ptr(id_reg);
                end else begin
                    arb_lock  = 1'b1;
                    arb_owner = id_reg;
                end
            end
            default: ;
        endcase
    end

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            fire;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (arb_ptr),
        .lock     (arb_lock),
        .owner    (arb_owner),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign fire      = arb_en && rst_n && (|grant);
    assign req_ready = (arb_en && rst_n) ? grant : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (fire) state_next = ST_BUSY;
            ST_BUSY: if (cnt_reg == '0) state_next = ST_RESP;
            ST_RESP: state_next = fire ? ST_BUSY : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            id_reg       <= '0;
            lock_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            last_reg     <= 1'b0;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            add_cin_reg  <= 1'b0;
            sum_cap_reg  <= '0;
            cout_cap_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == ST_BUSY) begin
                if (cnt_reg == '0) begin
                    sum_cap_reg  <= add_sum;
                    cout_cap_reg <= add_cout;
                end else begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end

            if (state_reg == ST_RESP) begin
                carry_reg <= cout_cap_reg;
                lock_reg  <= ~last_reg;
                if (last_reg) begin
                    ptr_reg <= next_ptr(id_reg);
                end else begin
                    owner_reg <= id_reg;
                end
            end

            // add_* are only reloaded on accept, so they hold through BUSY
            // and keep their last value afterwards.
            if (fire) begin
                add_a_reg   <= a_arr[grant_id];
                add_b_reg   <= b_arr[grant_id];
                add_cin_reg <= arb_lock ? carry_eff : req_cin[grant_id];
                last_reg    <= req_last[grant_id];
                id_reg      <= grant_id;
                cnt_reg     <= CNT_W'(ADD_LAT);
            end
        end
    end

    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = rsp_valid ? id_reg : '0;
    assign rsp_sum   = rsp_valid ? sum_cap_reg : '0;
    assign rsp_cout  = rsp_valid & cout_cap_reg;
    assign rsp_last  = rsp_valid & last_reg;

    assign add_a   = add_a_reg;
    assign add_b   = add_b_reg;
    assign add_cin = add_cin_reg;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: three instances (ADD_LAT = 1, 0, 3)
// share the request inputs; each has its own behavioural adder of matching
// latency. The ADD_LAT=1 instance is checked through a response scoreboard.
module tb_adder_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NREQ-1:0]   req_valid, req_last, req_cin;
    logic [NREQ*W-1:0] req_a, req_b;

    // ADD_LAT = 1 instance (m_), 0 (z_), 3 (t_)
    logic [NREQ-1:0] m_ready, z_ready, t_ready;
    logic            m_rsp_valid, z_rsp_valid, t_rsp_valid;
    logic [1:0]      m_rsp_id, z_rsp_id, t_rsp_id;
    logic [W-1:0]    m_rsp_sum, z_rsp_sum, t_rsp_sum;
    logic            m_rsp_cout, z_rsp_cout, t_rsp_cout;
    logic            m_rsp_last, z_rsp_last, t_rsp_last;
    logic [W-1:0]    m_add_a, z_add_a, t_add_a, m_add_b, z_add_b, t_add_b;
    logic            m_add_cin, z_add_cin, t_add_cin;
    logic [W-1:0]    m_add_sum, z_add_sum, t_add_sum;
    logic            m_add_cout, z_add_cout, t_add_cout;

    // Behavioural adders
    always @(posedge clk) {m_add_cout, m_add_sum} <= {1'b0, m_add_a} + {1'b0, m_add_b} + 9'(m_add_cin);
    assign {z_add_cout, z_add_sum} = {1'b0, z_add_a} + {1'b0, z_add_b} + 9'(z_add_cin);
    logic [8:0] t_s1, t_s2, t_s3;
    always @(posedge clk) begin
        t_s1 <= {1'b0, t_add_a} + {1'b0, t_add_b} + 9'(t_add_cin);
        t_s2 <= t_s1;
        t_s3 <= t_s2;
    end
    assign {t_add_cout, t_add_sum} = t_s3;

    adder_share_ctrl #(.NREQ(NREQ), .W(W), .ADD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ready(m_ready),
        .rsp_valid(m_rsp_valid), .rsp_id(m_rsp_id), .rsp_sum(m_rsp_sum),
        .rsp_cout(m_rsp_cout), .rsp_last(m_rsp_last), .add_a(m_add_a),
        .add_b(m_add_b), .add_cin(m_add_cin), .add_sum(m_add_sum), .add_cout(m_add_cout)
    );

    adder_share_ctrl #(.NREQ(NREQ), .W(W), .ADD_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ready(z_ready),
        .rsp_valid(z_rsp_valid), .rsp_id(z_rsp_id), .rsp_sum(z_rsp_sum),
        .rsp_cout(z_rsp_cout), .rsp_last(z_rsp_last), .add_a(z_add_a),
        .add_b(z_add_b), .add_cin(z_add_cin), .add_sum(z_add_sum), .add_cout(z_add_cout)
    );

    adder_share_ctrl #(.NREQ(NREQ), .W(W), .ADD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ready(t_ready),
        .rsp_valid(t_rsp_valid), .rsp_id(t_rsp_id), .rsp_sum(t_rsp_sum),
        .rsp_cout(t_rsp_cout), .rsp_last(t_rsp_last), .add_a(t_add_a),
        .add_b(t_add_b), .add_cin(t_add_cin), .add_sum(t_add_sum), .add_cout(t_add_cout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] id;
        logic [7:0] sum;
        logic       cout;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    function automatic logic [8:0] calc(input logic [7:0] a, input logic [7:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + 9'(cin);
    endfunction

    task automatic push_exp(input int id, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic last);
        logic [8:0] r;
        exp_t e;
        r = calc(a, b, cin);
        e.id = 2'(id); e.sum = r[7:0]; e.cout = r[8]; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic last);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_last[i]     = last;
        req_valid[i]    = 1'b1;
    endtask

    // Wait for requester i to be accepted by the ADD_LAT=1 instance, then drop its valid.
    task automatic wait_hs(input int i);
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_valid[i] && m_ready[i]) seen = 1;
        end
        chk($sformatf("handshake_req%0d", i), 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor on the ADD_LAT=1 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
        end else begin
            chk("ready_onehot", 32'($countones(m_ready) <= 1), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && m_ready[i]) acc_q.push_back(cyc);
            end
            if (m_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(m_rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] rsp id=%0d sum=%02h cout=%0d last=%0d (exp id=%0d sum=%02h cout=%0d last=%0d)",
                             m_rsp_id, m_rsp_sum, m_rsp_cout, m_rsp_last, e.id, e.sum, e.cout, e.last);
                    chk("rsp_id", 32'(m_rsp_id), 32'(e.id));
                    chk("rsp_sum", 32'(m_rsp_sum), 32'(e.sum));
                    chk("rsp_cout", 32'(m_rsp_cout), 32'(e.cout));
                    chk("rsp_last", 32'(m_rsp_last), 32'(e.last));
                    if (acc_q.size() > 0) begin
                        int a;
                        a = acc_q.pop_front();
                        chk("rsp_latency", 32'(cyc - a), 32'd3);
                    end else begin
                        chk("rsp_latency_acc", 32'(acc_q.size()), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int t0, cnt;
        int hs_cyc [5];

        req_valid = '0; req_last = '0; req_cin = '0; req_a = '0; req_b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_ready", 32'(m_ready), 32'd0);
        chk("reset_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("reset_add_a", 32'(m_add_a), 32'd0);
        chk("reset_add_cin", 32'(m_add_cin), 32'd0);
        @(posedge clk); #1;

        // Single beat on req0
        set_req(0, 8'd10, 8'd5, 1'b0, 1'b1);
        push_exp(0, 8'd10, 8'd5, 1'b0, 1'b1);
        wait_hs(0);
        drain();

        // Carry/overflow on req1
        set_req(1, 8'd200, 8'd100, 1'b1, 1'b1);
        push_exp(1, 8'd200, 8'd100, 1'b1, 1'b1);
        wait_hs(1);
        drain();

        // Carry chain on req2 with req1 waiting; pointer is now 2 so req2 wins
        set_req(1, 8'd7, 8'd9, 1'b0, 1'b1);
        set_req(2, 8'hFF, 8'h01, 1'b0, 1'b0);
        push_exp(2, 8'hFF, 8'h01, 1'b0, 1'b0);
        push_exp(2, 8'h01, 8'h00, 1'b1, 1'b1);
        push_exp(1, 8'd7, 8'd9, 1'b0, 1'b1);
        wait_hs(2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("lock_hold_ready", 32'(m_ready), 32'd0);
        end
        @(posedge clk); #1;
        set_req(2, 8'h01, 8'h00, 1'b0, 1'b1);
        wait_hs(2);
        wait_hs(1);
        drain();

        // Round robin from reset with all four valid
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 8'(16*i + 1), 8'(60*i + 5), 1'(i), 1'b1);
            push_exp(i, 8'(16*i + 1), 8'(60*i + 5), 1'(i), 1'b1);
        end
        push_exp(0, 8'd1, 8'd5, 1'b0, 1'b1);
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 5; k++) begin
            @(negedge clk);
            if (|(req_valid & m_ready)) begin
                hs_cyc[cnt] = cyc;
                cnt++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("rr_grant_count", 32'(cnt), 32'd5);
        for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
        drain();

        // Reset in the middle of a beat
        set_req(0, 8'h33, 8'h44, 1'b1, 1'b1);
        wait_hs(0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("midrst_rsp_sum", 32'(m_rsp_sum), 32'd0);
        chk("midrst_rsp_id", 32'(m_rsp_id), 32'd0);
        chk("midrst_add_a", 32'(m_add_a), 32'd0);
        chk("midrst_add_b", 32'(m_add_b), 32'd0);
        chk("midrst_add_cin", 32'(m_add_cin), 32'd0);
        chk("midrst_ready", 32'(m_ready), 32'd0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        set_req(1, 8'h11, 8'h22, 1'b0, 1'b1);
        set_req(3, 8'hF0, 8'h20, 1'b0, 1'b1);
        push_exp(1, 8'h11, 8'h22, 1'b0, 1'b1);
        push_exp(3, 8'hF0, 8'h20, 1'b0, 1'b1);
        wait_hs(1);
        wait_hs(3);
        drain();

        // Latency variants: ADD_LAT=0 -> T+2, ADD_LAT=3 -> T+5
        do_reset();
        set_req(0, 8'd10, 8'd5, 1'b0, 1'b1);
        push_exp(0, 8'd10, 8'd5, 1'b0, 1'b1);
        seen = 0;
        t0 = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (req_valid[0] && m_ready[0]) begin
                seen = 1;
                t0 = cyc;
            end
        end
        chk("lat_handshake", 32'(seen), 32'd1);
        chk("lat0_accept", 32'(z_ready), 32'd1);
        chk("lat3_accept", 32'(t_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("lat_cycle", 32'(cyc - t0), 32'(c));
            chk("lat0_rsp_valid", 32'(z_rsp_valid), 32'(c == 2));
            chk("lat3_rsp_valid", 32'(t_rsp_valid), 32'(c == 5));
            if (z_rsp_valid) begin
                chk("lat0_sum", 32'(z_rsp_sum), 32'd15);
                chk("lat0_cout", 32'(z_rsp_cout), 32'd0);
                chk("lat0_id", 32'(z_rsp_id), 32'd0);
                chk("lat0_last", 32'(z_rsp_last), 32'd1);
            end
            if (t_rsp_valid) begin
                chk("lat3_sum", 32'(t_rsp_sum), 32'd15);
                chk("lat3_cout", 32'(t_rsp_cout), 32'd0);
                chk("lat3_id", 32'(t_rsp_id), 32'd0);
                chk("lat3_last", 32'(t_rsp_last), 32'd1);
            end
            if (c == 1) begin
                chk("lat0_add_a", 32'(z_add_a), 32'd10);
                chk("lat0_add_b", 32'(z_add_b), 32'd5);
                chk("lat0_add_cin", 32'(z_add_cin), 32'd0);
            end
            if (c <= 4) begin
                chk("lat3_add_a", 32'(t_add_a), 32'd10);
                chk("lat3_add_b", 32'(t_add_b), 32'd5);
                chk("lat3_add_cin", 32'(t_add_cin), 32'd0);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Round-robin controller that shares one external W-bit ripple adder (a, b, cin -> sum, cout; clk port) between NREQ requesters.
- Each requester issues add beats over a valid/ready handshake.
- Multi-beat operations chain carry through the shared adder, so wider operands are added one byte per beat.
- Sits between client blocks and the single adder instance; the adder itself is unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/sum width per beat.
- ADD_LAT, 1, adder latency in cycles from add_* driven to add_sum/add_cout valid (0 = combinational).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  beat ends the operation (releases lock).
- req_a  in  NREQ*W  operand A; requester i at bits [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- req_cin  in  NREQ  carry-in, used on first beat only.
- req_ready  out  NREQ  one-hot grant/accept.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  clog2(NREQ)  requester of result.
- rsp_sum  out  W  beat sum.
- rsp_cout  out  1  beat carry-out.
- rsp_last  out  1  copy of accepted req_last.
- add_a, add_b  out  W  to adder.
- add_cin  out  1  to adder.
- add_sum  in  W  from adder.
- add_cout  in  1  from adder.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: req_ready=0, rsp_*=0, add_*=0.
  - State: FSM=IDLE, rr pointer=0, lock cleared, carry_reg=0.
  - Reset mid-operation discards the in-flight beat; no rsp_valid is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If unlocked, the winner is the first valid requester at or after the pointer, cyclically.
  - If locked, only the owner is eligible; others wait even when the owner's valid is low.
  - req_ready[winner]=1 combinationally in the same cycle; zero or one bit set.
  - On valid&ready at cycle T:
    - Register a, b, last and id.
    - Effective cin = lock ? carry_reg : req_cin.
    - Go to BUSY; load latency counter with ADD_LAT.
- BUSY:
  - add_a/add_b/add_cin are driven from registers starting cycle T+1 and held stable throughout.
  - Counter decrements each cycle.
  - At counter==0, capture add_sum/add_cout (cycle T+1+ADD_LAT) and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle (T+2+ADD_LAT) with captured sum/cout/id/last.
  - carry_reg <= cout.
  - If last=0: lock to id. If last=1: clear lock; pointer <= id+1 mod NREQ.
  - RESP behaves as IDLE for arbitration, using the updated lock/pointer, so a new beat may be accepted in the RESP cycle.
  - Throughput: one beat per ADD_LAT+2 cycles.
- No response backpressure; consumers must sample on rsp_valid.
- add_* hold their last values outside BUSY.
- Arithmetic: sum = (a+b+cin) mod 2^W; cout = bit W. No other overflow flag.
- The pointer does not advance on non-last beats. A locked chain cannot be preempted.

Decomposition:
- Package adder_share_pkg:
  - FSM state encoding (IDLE/BUSY/RESP).
  - Default NREQ/W/ADD_LAT constants.
  - ID width function clog2.
- One sub-module, rr_arbiter: inputs req mask, pointer, lock, owner; outputs one-hot grant and encoded id. Purely combinational.
- The controller holds all registers.

Test Plan (ADD_LAT=1 unless noted):
- Single beat: req0 a=10, b=5, cin=0, last=1 accepted at T -> rsp_valid at T+3, id=0, sum=15, cout=0, last=1.
- Carry/overflow: req1 a=200, b=100, cin=1 -> sum=45, cout=1; lock stays clear; pointer=2.
- Round robin: all four requesters valid continuously, last=1, from reset -> grants in order 0,1,2,3,0, spaced 3 cycles apart; req_ready never multi-hot.
- Carry chain on req2 (0x01FF+0x0001), with req1 held valid throughout:
  - Beat 1: a=0xFF, b=0x01, cin=0, last=0 -> sum=0x00, cout=1.
  - Beat 2: a=0x01, b=0x00, req_cin=0 (ignored), last=1 -> sum=0x02, cout=0.
  - req1 is not granted between the beats; it is granted right after beat 2.
- Reset mid-op: rst_n low for 1 cycle during BUSY -> no rsp_valid, all outputs 0. With req1 and req3 valid after release -> req1 granted first, then req3.
- ADD_LAT=0 and ADD_LAT=3 with the single-beat case -> rsp_valid at T+2 and T+5 respectively; results identical; add_* stable during BUSY.
